// File: rtl/ah_pl2ddr_pingpong_buf.sv
// Two-bank ping-pong buffer for the PL-to-DDR capture path.
// The producer fills one bank while the DDR-side reader drains the other.
module ah_pl2ddr_pingpong_buf #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic                  wr_flush,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  rd_last,
    output logic [ADDR_WIDTH:0]   rd_count,
    output logic [1:0]            banks_ready
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        RD_IDLE,
        RD_STREAM
    } rd_state_e;

    logic                  wr_bank_q, wr_bank_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic                  rd_bank_q, rd_bank_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [1:0]            bank_full_q, bank_full_d;
    logic [ADDR_WIDTH:0]   bank_len_q [2];
    logic [ADDR_WIDTH:0]   bank_len_d [2];
    rd_state_e             state_q, state_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  rd_last_q, rd_last_d;
    logic [ADDR_WIDTH:0]   rd_count_q, rd_count_d;
    logic [1:0]            banks_ready_q;
    logic [DATA_WIDTH-1:0] rd_data_q;

    logic [DATA_WIDTH-1:0] mem [2*DEPTH];

    logic                  wr_accept;
    logic                  wr_seal;
    logic [ADDR_WIDTH:0]   wr_len;
    logic [ADDR_WIDTH:0]   rd_len;
    logic                  rd_load;
    logic                  rd_release;
    logic [ADDR_WIDTH-1:0] rd_load_addr;

    assign wr_ready  = !bank_full_q[wr_bank_q];
    assign wr_accept = wr_valid && wr_ready;
    assign wr_len    = {1'b0, wr_addr_q} + (ADDR_WIDTH+1)'(wr_accept);
    // A flush only seals when the bank would otherwise hold at least one word.
    assign wr_seal   = (wr_accept && (wr_addr_q == ADDR_WIDTH'(DEPTH - 1)))
                    || (wr_flush && ((wr_addr_q != '0) || wr_accept));
    assign rd_len    = bank_len_q[rd_bank_q];

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        wr_bank_d = wr_bank_q;
        wr_addr_d = wr_addr_q;
        if (wr_seal) begin
            wr_bank_d = !wr_bank_q;
            wr_addr_d = '0;
        end else if (wr_accept) begin
            wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
        end
    end

    always_comb begin
        state_d      = state_q;
        rd_bank_d    = rd_bank_q;
        rd_addr_d    = rd_addr_q;
        rd_valid_d   = rd_valid_q;
        rd_last_d    = rd_last_q;
        rd_count_d   = rd_count_q;
        rd_load      = 1'b0;
        rd_release   = 1'b0;
        rd_load_addr = rd_addr_q;
        case (state_q)
            RD_IDLE: begin
                if (bank_full_q[rd_bank_q]) begin
                    rd_load      = 1'b1;
                    rd_load_addr = '0;
                    state_d      = RD_STREAM;
                end
            end
            RD_STREAM: begin
                if (rd_valid_q && rd_ready && rd_last_q) begin
                    rd_release = 1'b1;
                    rd_bank_d  = !rd_bank_q;
                    rd_addr_d  = '0;
                    rd_valid_d = 1'b0;
                    rd_last_d  = 1'b0;
                    state_d    = RD_IDLE;
                end else if (!rd_last_q && (!rd_valid_q || rd_ready)) begin
                    rd_load = 1'b1;
                end
            end
            default: state_d = RD_IDLE;
        endcase
        if (rd_load) begin
            rd_addr_d  = rd_load_addr + ADDR_WIDTH'(1);
            rd_valid_d = 1'b1;
            rd_last_d  = ({1'b0, rd_load_addr} == (rd_len - (ADDR_WIDTH+1)'(1)));
            rd_count_d = rd_len;
        end
    end

    // Seal and release always target different banks, so both may apply in one cycle.
    always_comb begin
        bank_full_d = bank_full_q;
        bank_len_d  = bank_len_q;
        if (wr_seal) begin
            bank_full_d[wr_bank_q] = 1'b1;
            bank_len_d[wr_bank_q]  = wr_len;
        end
        if (rd_release) begin
            bank_full_d[rd_bank_q] = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_bank_q     <= 1'b0;
            wr_addr_q     <= '0;
            rd_bank_q     <= 1'b0;
            rd_addr_q     <= '0;
            bank_full_q   <= '0;
            bank_len_q[0] <= '0;
            bank_len_q[1] <= '0;
            state_q       <= RD_IDLE;
            rd_valid_q    <= 1'b0;
            rd_last_q     <= 1'b0;
            rd_count_q    <= '0;
            banks_ready_q <= '0;
            rd_data_q     <= '0;
        end else begin
            wr_bank_q     <= wr_bank_d;
            wr_addr_q     <= wr_addr_d;
            rd_bank_q     <= rd_bank_d;
            rd_addr_q     <= rd_addr_d;
            bank_full_q   <= bank_full_d;
            bank_len_q    <= bank_len_d;
            state_q       <= state_d;
            rd_valid_q    <= rd_valid_d;
            rd_last_q     <= rd_last_d;
            rd_count_q    <= rd_count_d;
            banks_ready_q <= {1'b0, bank_full_d[0]} + {1'b0, bank_full_d[1]};
            if (rd_load) begin
                rd_data_q <= mem[{rd_bank_q, rd_load_addr}];
            end
        end
    end

    // NOTE: the array has no reset so it maps onto block RAM; words are written before read.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[{wr_bank_q, wr_addr_q}] <= wr_data;
        end
    end

    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign rd_last     = rd_last_q;
    assign rd_count    = rd_count_q;
    assign banks_ready = banks_ready_q;

endmodule
